// File: rtl/md_unit_ctrl.sv
// Multiply/divide controller beside the E-stage ALU: owns HI/LO, sequences
// multi-cycle mult/div with a busy counter, and requests D-stage stalls.
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MdOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic [1:0]  E_MdRead,
    input  logic        D_UseMd,
    output logic        Start,
    output logic        Busy,
    output logic        MdStall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MdOut
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [2*DW-1:0]  sa, sb, prod_s, prod_u;
    logic             a_neg, b_neg, div_zero;
    logic [DW-1:0]    mag_a, mag_b, quo_m, rem_m, quo_s, rem_s, quo_u, rem_u;

    // Arithmetic datapath; signed divide works on magnitudes so the
    // 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
    always_comb begin
        sa     = {{DW{E_A[DW-1]}}, E_A};
        sb     = {{DW{E_B[DW-1]}}, E_B};
        prod_s = sa * sb;
        prod_u = {{DW{1'b0}}, E_A} * {{DW{1'b0}}, E_B};

        a_neg    = E_A[DW-1];
        b_neg    = E_B[DW-1];
        div_zero = (E_B == '0);
        mag_a    = a_neg ? (~E_A + 32'd1) : E_A;
        mag_b    = b_neg ? (~E_B + 32'd1) : E_B;
        quo_m    = mag_a / mag_b;
        rem_m    = mag_a % mag_b;
        quo_s    = (a_neg ^ b_neg) ? (~quo_m + 32'd1) : quo_m;
        rem_s    = a_neg ? (~rem_m + 32'd1) : rem_m;
        quo_u    = E_A / E_B;
        rem_u    = E_A % E_B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Next-state: ops are only accepted in IDLE; anything arriving while busy is dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                case (E_MdOp)
                    OP_MULT, OP_MULTU: begin
                        pend_hi_d = (E_MdOp == OP_MULT) ? prod_s[2*DW-1:DW] : prod_u[2*DW-1:DW];
                        pend_lo_d = (E_MdOp == OP_MULT) ? prod_s[DW-1:0] : prod_u[DW-1:0];
                        cnt_d     = CNT_W'(MULT_CYCLES);
                        state_d   = ST_RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        if (div_zero) begin
                            pend_hi_d = hi_q;
                            pend_lo_d = lo_q;
                        end else if (E_MdOp == OP_DIV) begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                        end else begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                        end
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        state_d = ST_RUN;
                    end
                    OP_MTHI: hi_d = E_A;
                    OP_MTLO: lo_d = E_A;
                    default: ;
                endcase
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Start   = (E_MdOp >= OP_MULT) && (E_MdOp <= OP_DIVU);
        MdStall = D_UseMd & (Start | Busy);
        case (E_MdRead)
            2'b01:   E_MdOut = hi_q;
            2'b10:   E_MdOut = lo_q;
            default: E_MdOut = '0;
        endcase
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: vector table of mult/div results through a
// scoreboard queue, plus stall, mthi/read, reset-abort and back-to-back cases.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_MdOp;
    logic [31:0] E_A, E_B;
    logic [1:0]  E_MdRead;
    logic        D_UseMd;
    logic        Start, Busy, MdStall;
    logic [31:0] HI, LO, E_MdOut;

    always #5 clk = ~clk;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MdOp(E_MdOp), .E_A(E_A), .E_B(E_B),
        .E_MdRead(E_MdRead), .D_UseMd(D_UseMd), .Start(Start), .Busy(Busy),
        .MdStall(MdStall), .HI(HI), .LO(LO), .E_MdOut(E_MdOut)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    localparam int NV = 11;

    vec_t vecs[NV];
    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_acc = 0;
    logic proto_bad = 1'b0;

    // Illegal: a new md op reaching E while an operation is in flight.
    always @(negedge clk)
        if (!reset && Busy && E_MdOp != 3'd0) proto_bad <= 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MdOp = op;
        E_A    = a;
        E_B    = b;
        #1;
        chk("start", 32'(Start), 32'd1);
        stall_acc = MdStall ? 1 : 0;
        @(posedge clk);
        #1 E_MdOp = 3'd0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int   n = 0;
        bit   done = 1'b0;
        res_t e;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (MdStall) stall_acc++;
            if (Busy) n++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: Busy still high after 40 cycles", name);
        end
        chk({name, "_busy"}, 32'(n), 32'(exp_cyc));
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: no expected result queued", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_hi"}, HI, e.hi);
            chk({name, "_lo"}, LO, e.lo);
            E_MdRead = 2'b01;
            #1 chk({name, "_mfhi"}, E_MdOut, e.hi);
            E_MdRead = 2'b10;
            #1 chk({name, "_mflo"}, E_MdOut, e.lo);
            E_MdRead = 2'b00;
        end
    endtask

    initial begin
        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'd7,        32'd0,        32'h00000011, 32'h00000022, 10};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[6]  = '{3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[7]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[8]  = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[9]  = '{3'd3, 32'd0,        32'd0,        32'h00000011, 32'h00000022, 10};
        vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

        reset    = 1'b1;
        E_MdOp   = 3'd0;
        E_A      = '0;
        E_B      = '0;
        E_MdRead = 2'b00;
        D_UseMd  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_start", 32'(Start), 32'd0);
        D_UseMd = 1'b1;
        #1 chk("rst_stall", 32'(MdStall), 32'd0);
        D_UseMd = 1'b0;

        // Each vector runs from a known HI=0x11 / LO=0x22 so divide-by-zero is observable.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1 E_MdOp = 3'd5; E_A = 32'h11;
            @(posedge clk);
            #1 E_MdOp = 3'd6; E_A = 32'h22;
            @(posedge clk);
            #1;
            sb_q.push_back('{vecs[i].hi, vecs[i].lo});
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].cyc);
        end

        // Stall request: start cycle plus every busy cycle.
        @(posedge clk);
        #1 D_UseMd = 1'b1;
        sb_q.push_back('{32'd0, 32'd6});
        issue(3'd1, 32'd2, 32'd3);
        wait_done("stall", 5);
        chk("stall_cycles", 32'(stall_acc), 32'd6);
        chk("stall_after", 32'(MdStall), 32'd0);
        D_UseMd = 1'b0;
        @(posedge clk);
        #1;
        sb_q.push_back('{32'd0, 32'd20});
        issue(3'd1, 32'd4, 32'd5);
        wait_done("nostall", 5);
        chk("nostall_cycles", 32'(stall_acc), 32'd0);

        // Back-to-back: div issued in the single Busy=0 cycle after a multu.
        @(posedge clk);
        #1;
        sb_q.push_back('{32'd1, 32'd0});
        issue(3'd2, 32'h00010000, 32'h00010000);
        wait_done("b2b_mult", 5);
        chk("b2b_gap", 32'(Busy), 32'd0);
        sb_q.push_back('{32'd2, 32'd14});
        issue(3'd3, 32'd100, 32'd7);
        wait_done("b2b_div", 10);

        // Reset in the 4th busy cycle of a div aborts it.
        @(posedge clk);
        #1 issue(3'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        sb_q.push_back('{32'd0, 32'd12});
        issue(3'd1, 32'd3, 32'd4);
        wait_done("post_rst", 5);

        // mthi visible next cycle, reads need no stall.
        @(posedge clk);
        #1 E_MdOp = 3'd5; E_A = 32'hDEADBEEF;
        #1 chk("mthi_start", 32'(Start), 32'd0);
        @(posedge clk);
        #1 E_MdOp = 3'd0; E_MdRead = 2'b01;
        #1;
        chk("mthi_hi", HI, 32'hDEADBEEF);
        chk("mthi_mfhi", E_MdOut, 32'hDEADBEEF);
        chk("mthi_busy", 32'(Busy), 32'd0);
        chk("mthi_lo_kept", LO, 32'd12);
        E_MdRead = 2'b11;
        #1 chk("read_rsvd", E_MdOut, 32'd0);
        E_MdRead = 2'b00;
        #1 chk("read_none", E_MdOut, 32'd0);

        @(negedge clk);
        chk("protocol", 32'(proto_bad), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It sits beside the E-stage ALU and owns the HI/LO registers. It sequences multi-cycle mult/multu/div/divu operations with a busy counter and services mthi/mtlo/mfhi/mflo. It raises a stall request that the hazard unit ORs into its global stall, so that no HI/LO-using instruction leaves D while an operation is pending.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- E_MdOp  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- E_A  in  32  rs operand, already forwarded.
- E_B  in  32  rt operand, already forwarded.
- E_MdRead  in  2  00 none, 01 mfhi, 10 mflo, 11 reserved (reads 0).
- D_UseMd  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Start  out  1  combinational; E_MdOp is 1..4 this cycle.
- Busy  out  1  registered; an operation is in flight.
- MdStall  out  1  combinational; D_UseMd & (Start | Busy).
- HI  out  32  HI register.
- LO  out  32  LO register.
- E_MdOut  out  32  combinational; HI if E_MdRead=01, LO if 10, else 0.

## Operation
- Reset: Busy=0, counter=0, HI=0, LO=0, pending result=0. Reset has priority over everything. Reset during an operation discards it, and the counter and HI/LO read 0 after the edge.
- State is IDLE (counter=0, Busy=0) or RUN (counter>0, Busy=1). Busy = (counter != 0), registered.
- IDLE with E_MdOp in 1..4, at the edge:
  - latch the full result into pending HI/LO;
  - counter := MULT_CYCLES or DIV_CYCLES;
  - move to RUN.
- RUN: counter decrements each edge. On the edge where counter goes 1->0, HI/LO := pending and the unit returns to IDLE.
- mult: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0]. multu is unsigned.
- div (signed): LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. divu is unsigned.
- Divide by zero: the unit still runs DIV_CYCLES, and at completion pending HI/LO equal the prior HI/LO (values unchanged).
- mthi/mtlo in IDLE: HI (or LO) := E_A at the edge. No busy, no other register changes.
- Any E_MdOp other than 0 while Busy=1 is a protocol violation and must never occur, because MdStall holds such instructions in D. The RTL ignores it, and the bench asserts it never happens.
- Reads are combinational from the architectural HI/LO. A read during RUN returns the old value; the stall prevents this in legal code.

## Timing
- An op presented in E during cycle c is sampled at edge e0. Busy=1 in cycles c+1 .. c+N. HI/LO take new values at edge eN, the same edge on which Busy falls. N = MULT_CYCLES or DIV_CYCLES.
- MdStall is asserted in cycle c (via Start) and in cycles c+1..c+N (via Busy) whenever D_UseMd=1. A dependent mfhi therefore enters E no earlier than cycle c+N+1 and sees the result.
- A new mult/div may start in the first cycle with Busy=0 (back-to-back, no bubble beyond the stall).
- mthi/mtlo result is visible on HI/LO in the next cycle. mfhi in the following E cycle reads it with no stall needed.
- Zero-latency outputs: Start, MdStall, E_MdOut.

## Test plan
- Reset then mult with E_A=0xFFFFFFFF (-1), E_B=2 -> Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div with E_A=-7 (0xFFFFFFF9), E_B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=0x11, LO=0x22 -> still 10 busy cycles; HI/LO stay 0x11/0x22.
- Hold D_UseMd=1 while a mult starts -> MdStall=1 for 6 consecutive cycles (start plus 5 busy), then 0. With D_UseMd=0 -> MdStall=0 throughout.
- mthi E_A=0xDEADBEEF, then mflo/mfhi reads -> HI=0xDEADBEEF next cycle; E_MdRead=01 gives 0xDEADBEEF, and E_MdRead=11 gives 0.
- Start div, assert reset at busy cycle 4 -> Busy=0, HI=LO=0 after the edge. A following mult completes normally in 5 cycles.
- Back-to-back: mult completes, and div is issued in the first cycle with Busy=0 -> Busy drops for exactly one cycle (the start cycle), and the div result is correct.
